// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control unit.
//   reg_idx_t : architectural register index (x0..x31)
//   memfsm_e  : data-memory wait FSM states
//   ZERO_REG  : index of the hard-wired zero register, never a real hazard source
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W_DEF = 5;

  typedef logic [REG_IDX_W_DEF-1:0] reg_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memfsm_e;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating performance counter: increments by one on every clock where
// inc_i is high and sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears the count
//   inc_i : count this cycle
//   cnt_o : current count
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard and pipeline-control unit for the 5-stage F/D/E/M/W core.
// Detects D/E load-use hazards, turns E-stage redirects into D/E flushes and
// freezes the whole pipe while a data-memory access in M is outstanding.
// Control outputs are purely combinational from inputs and FSM state.
//   clk, rst                 : clock, asynchronous active-low reset
//   rs1/rs2_idx_D, *_used_D  : source operands of the instruction in D
//   rd_idx_E, is_load_E      : destination / load flag of the instruction in E
//   jb_E                     : taken branch or jump resolved in E
//   dmem_req_M, dmem_ready   : M-stage memory handshake
//   hold_*/bubble_E/flush_*  : pipeline-register controls
//   mem_timeout              : sticky flag, memory wait exceeded MEM_TIMEOUT
//   stall_cnt, flush_cnt     : saturating perf counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W   = 5,
  parameter int PERF_W      = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_idx_D,
  input  logic [REG_IDX_W-1:0] rs2_idx_D,
  input  logic                 rs1_used_D,
  input  logic                 rs2_used_D,
  input  logic [REG_IDX_W-1:0] rd_idx_E,
  input  logic                 is_load_E,
  input  logic                 jb_E,
  input  logic                 dmem_req_M,
  input  logic                 dmem_ready,
  output logic                 hold_F,
  output logic                 hold_D,
  output logic                 flush_D,
  output logic                 bubble_E,
  output logic                 flush_E,
  output logic                 hold_E,
  output logic                 hold_M,
  output logic                 mem_timeout,
  output logic [PERF_W-1:0]    stall_cnt,
  output logic [PERF_W-1:0]    flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  memfsm_e             state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                mem_freeze;
  logic                load_use;

  // A request that is answered in the same cycle never freezes; only an
  // unanswered request (new or already waiting) does.
  assign mem_freeze = ((state_q == IDLE) && dmem_req_M && !dmem_ready) ||
                      ((state_q == WAIT) && !dmem_ready);

  assign load_use = is_load_E && (rd_idx_E != REG_IDX_W'(ZERO_REG)) &&
                    ((rs1_used_D && (rs1_idx_D == rd_idx_E)) ||
                     (rs2_used_D && (rs2_idx_D == rd_idx_E)));

  // Priority: freeze > redirect > load-use. A redirect squashes the dependent
  // D instruction, so a coincident load-use needs no bubble.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if/else chain can infer a latch.
    hold_F   = 1'b0;
    hold_D   = 1'b0;
    hold_E   = 1'b0;
    hold_M   = 1'b0;
    bubble_E = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    if (!rst) begin
      // pipe controls stay inactive while reset is asserted
    end else if (mem_freeze) begin
      hold_F = 1'b1;
      hold_D = 1'b1;
      hold_E = 1'b1;
      hold_M = 1'b1;
    end else if (jb_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      hold_F   = 1'b1;
      hold_D   = 1'b1;
      bubble_E = 1'b1;
    end
  end

  // Memory wait FSM, wait counter and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      IDLE: if (dmem_req_M && !dmem_ready) state_d = WAIT;
      WAIT: if (dmem_ready)                state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
    if ((state_q == WAIT) && (state_d == WAIT)) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                        : wait_cnt_q + WAIT_W'(1);
    end
    if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  perf_sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hold_F | hold_D | hold_E | hold_M | bubble_E),
    .cnt_o (stall_cnt)
  );

  perf_sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_E),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge,
// combinational outputs are sampled 1 ns later, registered values are
// sampled on the falling edge after the rising edge that updated them.
module tb_pipe_hazard_ctrl;

  localparam int REG_IDX_W = 5;
  localparam int PERF_W    = 32;

  // ctrl = {hold_F, hold_D, hold_E, hold_M, bubble_E, flush_D, flush_E}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1111000;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_FLUSH  = 7'b0000011;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REG_IDX_W-1:0] rs1_idx_D, rs2_idx_D, rd_idx_E;
  logic                 rs1_used_D, rs2_used_D, is_load_E, jb_E;
  logic                 dmem_req_M, dmem_ready;
  logic                 hold_F, hold_D, flush_D, bubble_E, flush_E, hold_E, hold_M;
  logic                 mem_timeout;
  logic [PERF_W-1:0]    stall_cnt, flush_cnt;
  logic [6:0]           ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  assign ctrl = {hold_F, hold_D, hold_E, hold_M, bubble_E, flush_D, flush_E};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_IDX_W   (REG_IDX_W),
    .PERF_W      (PERF_W),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_idx_D   (rs1_idx_D),
    .rs2_idx_D   (rs2_idx_D),
    .rs1_used_D  (rs1_used_D),
    .rs2_used_D  (rs2_used_D),
    .rd_idx_E    (rd_idx_E),
    .is_load_E   (is_load_E),
    .jb_E        (jb_E),
    .dmem_req_M  (dmem_req_M),
    .dmem_ready  (dmem_ready),
    .hold_F      (hold_F),
    .hold_D      (hold_D),
    .flush_D     (flush_D),
    .bubble_E    (bubble_E),
    .flush_E     (flush_E),
    .hold_E      (hold_E),
    .hold_M      (hold_M),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic idle_inputs();
    rs1_idx_D  = '0; rs2_idx_D  = '0; rd_idx_E  = '0;
    rs1_used_D = 0;  rs2_used_D = 0;  is_load_E = 0;
    jb_E       = 0;  dmem_req_M = 0;  dmem_ready = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] idx);
    is_load_E = 1; rd_idx_E = idx; rs1_used_D = 1; rs1_idx_D = idx;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    set_load_use(5'd9);
    jb_E = 1; dmem_req_M = 1;
    #3;
    n_checks++;
    if (ctrl !== C_NONE) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NONE);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_timeout, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: timeout=%b stall=%0d flush=%0d want all 0",
               mem_timeout, stall_cnt, flush_cnt);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5);
    #1;
    n_checks++;
    if (ctrl !== C_LU) begin
      n_fail++; $display("FAIL lu_cycle1: got %b want %b", ctrl, C_LU);
    end
    @(negedge clk);
    is_load_E = 0;
    #1;
    n_checks++;
    if (ctrl !== C_NONE) begin
      n_fail++; $display("FAIL lu_cycle2: got %b want %b", ctrl, C_NONE);
    end
    n_checks++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL lu_counts: stall=%0d flush=%0d want 1 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_filter();
    apply_reset();
    // load to x0 never stalls
    is_load_E = 1; rd_idx_E = 5'd0; rs1_used_D = 1; rs1_idx_D = 5'd0;
    #1;
    n_checks++;
    if (ctrl !== C_NONE) begin
      n_fail++; $display("FAIL filter_x0: got %b want %b", ctrl, C_NONE);
    end
    // matching rs2 that the instruction does not read
    @(negedge clk);
    rd_idx_E = 5'd7; rs1_idx_D = 5'd3; rs2_idx_D = 5'd7; rs2_used_D = 0;
    #1;
    n_checks++;
    if (ctrl !== C_NONE) begin
      n_fail++; $display("FAIL filter_rs2_unused: got %b want %b", ctrl, C_NONE);
    end
    // same operands, rs2 now used -> real hazard
    @(negedge clk);
    rs2_used_D = 1;
    #1;
    n_checks++;
    if (ctrl !== C_LU) begin
      n_fail++; $display("FAIL filter_rs2_used: got %b want %b", ctrl, C_LU);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL filter_stall_cnt: got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    set_load_use(5'd12);
    jb_E = 1;
    #1;
    n_checks++;
    if (ctrl !== C_FLUSH) begin
      n_fail++; $display("FAIL redirect_ctrl: got %b want %b", ctrl, C_FLUSH);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0 || ctrl !== C_NONE) begin
      n_fail++;
      $display("FAIL redirect_after: flush=%0d stall=%0d ctrl=%b want 1 0 %b",
               flush_cnt, stall_cnt, ctrl, C_NONE);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    dmem_req_M = 1; dmem_ready = 0; jb_E = 1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_checks++;
      if (ctrl !== C_FREEZE) begin
        n_fail++; $display("FAIL memwait_freeze[%0d]: got %b want %b", i, ctrl, C_FREEZE);
      end
    end
    @(negedge clk);
    dmem_ready = 1;
    #1;
    n_checks++;
    if (ctrl !== C_FLUSH) begin
      n_fail++; $display("FAIL memwait_release: got %b want %b", ctrl, C_FLUSH);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1 || ctrl !== C_NONE || mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL memwait_after: stall=%0d flush=%0d ctrl=%b to=%b want 3 1 %b 0",
               stall_cnt, flush_cnt, ctrl, mem_timeout, C_NONE);
    end
  endtask

  task automatic test_timeout_reset();
    apply_reset();
    dmem_req_M = 1; dmem_ready = 0;
    // first edge enters WAIT; timeout expected after the 4th WAIT cycle
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_timeout !== (k == 4)) begin
        n_fail++; $display("FAIL timeout_wait[%0d]: got %b want %b", k, mem_timeout, k == 4);
      end
    end
    dmem_req_M = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_timeout !== 1'b1 || ctrl !== C_FREEZE || stall_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL timeout_sticky: to=%b ctrl=%b stall=%0d want 1 %b 6",
               mem_timeout, ctrl, stall_cnt, C_FREEZE);
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || ctrl !== C_NONE) begin
      n_fail++;
      $display("FAIL timeout_reset: to=%b stall=%0d flush=%0d ctrl=%b want all 0",
               mem_timeout, stall_cnt, flush_cnt, ctrl);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    // ready still low: a leftover WAIT state would freeze here
    n_checks++;
    if (ctrl !== C_NONE) begin
      n_fail++; $display("FAIL timeout_idle_after_reset: got %b want %b", ctrl, C_NONE);
    end
  endtask

  task automatic test_zero_wait();
    apply_reset();
    dmem_req_M = 1; dmem_ready = 1;
    #1;
    n_checks++;
    if (ctrl !== C_NONE) begin
      n_fail++; $display("FAIL zerowait_ctrl: got %b want %b", ctrl, C_NONE);
    end
    @(negedge clk);
    dmem_req_M = 0; dmem_ready = 0;
    #1;
    n_checks++;
    if (ctrl !== C_NONE || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL zerowait_stays_idle: ctrl=%b stall=%0d want %b 0", ctrl, stall_cnt, C_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_filter();
    test_redirect();
    test_mem_wait();
    test_timeout_reset();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
